// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage core pipeline control: forwarding selects,
// hazard-controller states and the per-stage enable/flush bundle.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_ALU  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_UP16 = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hzd_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_FREEZE = '0;

  // Stage control once halt and memory-wait have been ruled out; the
  // if/else order is the hazard priority.
  function automatic stage_ctrl_t run_ctrl(input logic branch, input logic loaduse,
                                           input logic jump, input logic ihit);
    stage_ctrl_t c;
    c.pc_en       = 1'b1;
    c.if_id_en    = 1'b1;
    c.id_ex_en    = 1'b1;
    c.ex_mem_en   = 1'b1;
    c.mem_wb_en   = 1'b1;
    c.if_id_flush = 1'b0;
    c.id_ex_flush = 1'b0;
    if (branch) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (loaduse) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end else if (jump) begin
      c.if_id_flush = 1'b1;
    end else if (!ihit) begin
      c.pc_en       = 1'b0;
      c.if_id_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/forward_sel.sv
// Operand forwarding select for one ALU source: EX/MEM beats MEM/WB, and
// register 0 is never forwarded.
module forward_sel
  import cpu_types_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       regwrite_ex_mem_i,
  input  logic [4:0] wsel_ex_mem_i,
  input  logic       lui_ex_mem_i,
  input  logic       regwrite_mem_wb_i,
  input  logic [4:0] wsel_mem_wb_i,
  output fwd_sel_t   sel_o
);

  logic hit_ex_mem;
  logic hit_mem_wb;

  assign hit_ex_mem = regwrite_ex_mem_i && (wsel_ex_mem_i != 5'd0) && (wsel_ex_mem_i == src_i);
  assign hit_mem_wb = regwrite_mem_wb_i && (wsel_mem_wb_i != 5'd0) && (wsel_mem_wb_i == src_i);

  always_comb begin
    if (hit_ex_mem)      sel_o = lui_ex_mem_i ? FWD_UP16 : FWD_ALU;
    else if (hit_mem_wb) sel_o = FWD_WB;
    else                 sel_o = FWD_RF;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline controller: forwarding selects, hazard stalls/flushes, memory-wait
// and halt sequencing, wait watchdog and saturating stall counter.
module hazard_forward_ctrl
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       rs_id_ex,
  input  logic [4:0]       rt_id_ex,
  input  logic [4:0]       rs_if_id,
  input  logic [4:0]       rt_if_id,
  input  logic             memread_id_ex,
  input  logic [4:0]       wsel_id_ex,
  input  logic             regwrite_ex_mem,
  input  logic [4:0]       wsel_ex_mem,
  input  logic             lui_ex_mem,
  input  logic             regwrite_mem_wb,
  input  logic [4:0]       wsel_mem_wb,
  input  logic             dmemren_ex_mem,
  input  logic             dmemwen_ex_mem,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             branch_taken_ex_mem,
  input  logic             jump_id,
  input  logic             halt_mem_wb,
  output logic [1:0]       forwarda,
  output logic [1:0]       forwardb,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = 8;

  fwd_sel_t         fwd_a, fwd_b;
  hzd_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  stage_ctrl_t      ctrl;
  logic             memwait, loaduse;

  forward_sel u_fwd_a (
    .src_i             (rs_id_ex),
    .regwrite_ex_mem_i (regwrite_ex_mem),
    .wsel_ex_mem_i     (wsel_ex_mem),
    .lui_ex_mem_i      (lui_ex_mem),
    .regwrite_mem_wb_i (regwrite_mem_wb),
    .wsel_mem_wb_i     (wsel_mem_wb),
    .sel_o             (fwd_a)
  );

  forward_sel u_fwd_b (
    .src_i             (rt_id_ex),
    .regwrite_ex_mem_i (regwrite_ex_mem),
    .wsel_ex_mem_i     (wsel_ex_mem),
    .lui_ex_mem_i      (lui_ex_mem),
    .regwrite_mem_wb_i (regwrite_mem_wb),
    .wsel_mem_wb_i     (wsel_mem_wb),
    .sel_o             (fwd_b)
  );

  assign memwait = (dmemren_ex_mem || dmemwen_ex_mem) && !dhit;
  assign loaduse = memread_id_ex && (wsel_id_ex != 5'd0) &&
                   ((wsel_id_ex == rs_if_id) || (wsel_id_ex == rt_if_id));

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ctrl       = CTRL_FREEZE;
    unique case (state_q)
      RUN: begin
        if (halt_mem_wb)  state_d = HALT;
        else if (memwait) state_d = MEM_WAIT;
        else              ctrl = run_ctrl(branch_taken_ex_mem, loaduse, jump_id, ihit);
      end
      MEM_WAIT: begin
        if (dhit) begin
          ctrl       = run_ctrl(branch_taken_ex_mem, loaduse, jump_id, ihit);
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == WAIT_W'(MAX_WAIT - 1)) timeout_d = 1'b1;
        end
      end
      HALT: ;
      default: state_d = RUN;
    endcase
  end

  assign stall_cnt_d = (!ctrl.pc_en && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                            : stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are held low for the whole time reset is asserted.
  assign forwarda    = nRST ? fwd_a : 2'b00;
  assign forwardb    = nRST ? fwd_b : 2'b00;
  assign pc_en       = nRST & ctrl.pc_en;
  assign if_id_en    = nRST & ctrl.if_id_en;
  assign id_ex_en    = nRST & ctrl.id_ex_en;
  assign ex_mem_en   = nRST & ctrl.ex_mem_en;
  assign mem_wb_en   = nRST & ctrl.mem_wb_en;
  assign if_id_flush = nRST & ctrl.if_id_flush;
  assign id_ex_flush = nRST & ctrl.id_ex_flush;
  assign halted      = nRST & (state_q == HALT);
  assign mem_timeout = timeout_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed self-checking bench for hazard_forward_ctrl (MAX_WAIT=3).
module tb_hazard_forward_ctrl;

  localparam int CNT_W = 16;

  logic CLK = 1'b0;
  logic nRST;
  logic [4:0] rs_id_ex, rt_id_ex, rs_if_id, rt_if_id, wsel_id_ex, wsel_ex_mem, wsel_mem_wb;
  logic memread_id_ex, regwrite_ex_mem, lui_ex_mem, regwrite_mem_wb;
  logic dmemren_ex_mem, dmemwen_ex_mem, dhit, ihit, branch_taken_ex_mem, jump_id, halt_mem_wb;
  logic [1:0] forwarda, forwardb;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic halted, mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [6:0] ctl;

  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  hazard_forward_ctrl #(.MAX_WAIT(3), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .rs_id_ex(rs_id_ex), .rt_id_ex(rt_id_ex), .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
    .memread_id_ex(memread_id_ex), .wsel_id_ex(wsel_id_ex),
    .regwrite_ex_mem(regwrite_ex_mem), .wsel_ex_mem(wsel_ex_mem), .lui_ex_mem(lui_ex_mem),
    .regwrite_mem_wb(regwrite_mem_wb), .wsel_mem_wb(wsel_mem_wb),
    .dmemren_ex_mem(dmemren_ex_mem), .dmemwen_ex_mem(dmemwen_ex_mem),
    .dhit(dhit), .ihit(ihit), .branch_taken_ex_mem(branch_taken_ex_mem),
    .jump_id(jump_id), .halt_mem_wb(halt_mem_wb),
    .forwarda(forwarda), .forwardb(forwardb),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  task automatic set_idle();
    rs_id_ex = 0; rt_id_ex = 0; rs_if_id = 0; rt_if_id = 0; wsel_id_ex = 0;
    wsel_ex_mem = 0; wsel_mem_wb = 0; memread_id_ex = 0; regwrite_ex_mem = 0;
    lui_ex_mem = 0; regwrite_mem_wb = 0; dmemren_ex_mem = 0; dmemwen_ex_mem = 0;
    dhit = 0; ihit = 1; branch_taken_ex_mem = 0; jump_id = 0; halt_mem_wb = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    set_idle();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    nRST = 1'b0;
    regwrite_ex_mem = 1; wsel_ex_mem = 3; rs_id_ex = 3;
    #12;
    compared++;
    if (ctl !== 7'b0) begin
      mismatched++; $display("FAIL rst_ctl: got %b want %b", ctl, 7'b0);
    end
    compared++;
    if (forwarda !== 2'b00) begin
      mismatched++; $display("FAIL rst_fwda: got %b want 00", forwarda);
    end
    compared++;
    if ({halted, mem_timeout, stall_count} !== '0) begin
      mismatched++; $display("FAIL rst_state: got %b/%b/%0d want 0/0/0", halted, mem_timeout, stall_count);
    end
    apply_reset();
    compared++;
    if (ctl !== 7'b1111100) begin
      mismatched++; $display("FAIL run_idle_ctl: got %b want 1111100", ctl);
    end
  endtask

  task automatic test_forward();
    set_idle();
    regwrite_ex_mem = 1; wsel_ex_mem = 3; rs_id_ex = 3; #1;
    compared++;
    if (forwarda !== 2'b01) begin
      mismatched++; $display("FAIL fwd_exmem: got %b want 01", forwarda);
    end
    lui_ex_mem = 1; #1;
    compared++;
    if (forwarda !== 2'b11) begin
      mismatched++; $display("FAIL fwd_lui: got %b want 11", forwarda);
    end
    lui_ex_mem = 0; wsel_ex_mem = 5; regwrite_mem_wb = 1; wsel_mem_wb = 5; rt_id_ex = 5; #1;
    compared++;
    if (forwardb !== 2'b01) begin
      mismatched++; $display("FAIL fwd_priority: got %b want 01", forwardb);
    end
    compared++;
    if (forwarda !== 2'b00) begin
      mismatched++; $display("FAIL fwd_nomatch: got %b want 00", forwarda);
    end
    wsel_ex_mem = 7; #1;
    compared++;
    if (forwardb !== 2'b10) begin
      mismatched++; $display("FAIL fwd_memwb: got %b want 10", forwardb);
    end
    wsel_ex_mem = 5; regwrite_ex_mem = 0; #1;
    compared++;
    if (forwardb !== 2'b10) begin
      mismatched++; $display("FAIL fwd_nowrite: got %b want 10", forwardb);
    end
    regwrite_ex_mem = 1; wsel_ex_mem = 0; wsel_mem_wb = 0; rt_id_ex = 0; #1;
    compared++;
    if (forwardb !== 2'b00) begin
      mismatched++; $display("FAIL fwd_r0: got %b want 00", forwardb);
    end
    set_idle();
  endtask

  task automatic test_loaduse();
    set_idle();
    memread_id_ex = 1; wsel_id_ex = 4; rs_if_id = 4; #1;
    compared++;
    if (ctl !== 7'b0011101) begin
      mismatched++; $display("FAIL lu_stall: got %b want 0011101", ctl);
    end
    tick();
    set_idle();
    regwrite_mem_wb = 1; wsel_mem_wb = 4; rs_id_ex = 4; #1;
    compared++;
    if (forwarda !== 2'b10 || ctl !== 7'b1111100) begin
      mismatched++; $display("FAIL lu_after: got %b/%b want 10/1111100", forwarda, ctl);
    end
    set_idle();
    memread_id_ex = 1; wsel_id_ex = 0; #1;
    compared++;
    if (ctl !== 7'b1111100) begin
      mismatched++; $display("FAIL lu_r0: got %b want 1111100", ctl);
    end
    memread_id_ex = 1; wsel_id_ex = 9; rt_if_id = 9; #1;
    compared++;
    if (ctl !== 7'b0011101) begin
      mismatched++; $display("FAIL lu_rt: got %b want 0011101", ctl);
    end
    set_idle();
  endtask

  task automatic test_priority();
    set_idle();
    branch_taken_ex_mem = 1; memread_id_ex = 1; wsel_id_ex = 4; rs_if_id = 4; ihit = 0; #1;
    compared++;
    if (ctl !== 7'b1111111) begin
      mismatched++; $display("FAIL pri_branch: got %b want 1111111", ctl);
    end
    branch_taken_ex_mem = 0; #1;
    compared++;
    if (ctl !== 7'b0011101) begin
      mismatched++; $display("FAIL pri_loaduse: got %b want 0011101", ctl);
    end
    memread_id_ex = 0; jump_id = 1; #1;
    compared++;
    if (ctl !== 7'b1111110) begin
      mismatched++; $display("FAIL pri_jump: got %b want 1111110", ctl);
    end
    jump_id = 0; #1;
    compared++;
    if (ctl !== 7'b0111110) begin
      mismatched++; $display("FAIL pri_imiss: got %b want 0111110", ctl);
    end
    set_idle();
  endtask

  task automatic test_memwait();
    apply_reset();
    dmemren_ex_mem = 1; dhit = 0; #1;
    compared++;
    if (ctl !== 7'b0) begin
      mismatched++; $display("FAIL mw_entry: got %b want 0000000", ctl);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (ctl !== 7'b0) begin
        mismatched++; $display("FAIL mw_wait%0d: got %b want 0000000", i, ctl);
      end
      if (i == 1) begin
        compared++;
        if (mem_timeout !== 1'b0) begin
          mismatched++; $display("FAIL mw_early_timeout: got %b want 0", mem_timeout);
        end
      end
    end
    tick();
    dhit = 1; #1;
    compared++;
    if (ctl !== 7'b1111100 || stall_count !== 16'd4 || mem_timeout !== 1'b1) begin
      mismatched++;
      $display("FAIL mw_release: got %b/%0d/%b want 1111100/4/1", ctl, stall_count, mem_timeout);
    end
    tick();
    set_idle(); #1;
    compared++;
    if (ctl !== 7'b1111100 || stall_count !== 16'd4 || mem_timeout !== 1'b1) begin
      mismatched++;
      $display("FAIL mw_sticky: got %b/%0d/%b want 1111100/4/1", ctl, stall_count, mem_timeout);
    end
  endtask

  task automatic test_halt();
    set_idle();
    halt_mem_wb = 1; #1;
    compared++;
    if (ctl !== 7'b0 || halted !== 1'b0) begin
      mismatched++; $display("FAIL halt_entry: got %b/%b want 0000000/0", ctl, halted);
    end
    tick();
    halt_mem_wb = 0;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (ctl !== 7'b0 || halted !== 1'b1) begin
        mismatched++; $display("FAIL halt_hold%0d: got %b/%b want 0000000/1", i, ctl, halted);
      end
      tick();
    end
    compared++;
    if (stall_count !== 16'd10) begin
      mismatched++; $display("FAIL halt_stalls: got %0d want 10", stall_count);
    end
    #2 nRST = 1'b0; #1;
    compared++;
    if (halted !== 1'b0 || ctl !== 7'b0 || stall_count !== '0 || mem_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_rst: got %b/%b/%0d/%b want 0/0000000/0/0", halted, ctl, stall_count, mem_timeout);
    end
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    compared++;
    if (halted !== 1'b0 || ctl !== 7'b1111100 || stall_count !== '0) begin
      mismatched++;
      $display("FAIL halt_restart: got %b/%b/%0d want 0/1111100/0", halted, ctl, stall_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_loaduse();
    test_priority();
    test_memwait();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline controller for the 5-stage core.
- Generates the 2-bit forwarding selects for the ALU A and B operand muxes in EX.
- Detects load-use hazards, instruction-fetch misses, data-memory waits, taken branches/jumps and halt.
- Drives per-stage latch enables and flushes, with a small state machine that sequences memory-wait and halt, plus a wait-timeout watchdog and a stall counter.

Parameters:
- MAX_WAIT, 64, consecutive MEM_WAIT cycles before mem_timeout is set (range 2..255).
- CNT_W, 16, width of stall_count.

Ports:
- CLK  in  1  core clock; all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- rs_id_ex, rt_id_ex  in  5  source registers of instruction in EX
- rs_if_id, rt_if_id  in  5  source registers of instruction in ID
- memread_id_ex  in  1  instruction in EX is a load
- wsel_id_ex  in  5  destination of instruction in EX
- regwrite_ex_mem  in  1  EX/MEM instruction writes the register file
- wsel_ex_mem  in  5  destination of EX/MEM instruction
- lui_ex_mem  in  1  EX/MEM instruction is LUI (result is on the upper16 path)
- regwrite_mem_wb  in  1  MEM/WB instruction writes the register file
- wsel_mem_wb  in  5  destination of MEM/WB instruction
- dmemren_ex_mem, dmemwen_ex_mem  in  1  data-memory access in MEM
- dhit  in  1  data access completes this cycle
- ihit  in  1  instruction fetch completes this cycle
- branch_taken_ex_mem  in  1  branch resolved taken in MEM
- jump_id  in  1  J/JAL/JR decoded in ID
- halt_mem_wb  in  1  HALT reached WB
- forwarda, forwardb  out  2  operand select: 00 regfile, 01 EX/MEM aluresult, 10 WB writedata, 11 EX/MEM upper16
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage latch enables
- if_id_flush, id_ex_flush  out  1 each  load bubble into the latch
- halted  out  1  core halted
- mem_timeout  out  1  sticky watchdog flag
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
Reset and state:
- nRST=0 asynchronously sets state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0, halted=0.
- While nRST=0 all outputs are forced to 0: enables 0, flushes 0, forwarda/b=00.
- States: RUN, MEM_WAIT, HALT.

Forwarding (combinational, evaluated identically for A using rs_id_ex and for B using rt_id_ex):
- EX/MEM match (regwrite_ex_mem, wsel_ex_mem!=0, wsel_ex_mem==src) → 11 if lui_ex_mem, else 01.
- Otherwise MEM/WB match (regwrite_mem_wb, wsel_mem_wb!=0, wsel_mem_wb==src) → 10.
- Otherwise 00.
- EX/MEM has priority over MEM/WB. Register 0 never forwards.

Hazard terms:
- memwait = (dmemren_ex_mem | dmemwen_ex_mem) & ~dhit
- loaduse = memread_id_ex & wsel_id_ex!=0 & (wsel_id_ex==rs_if_id | wsel_id_ex==rt_if_id)

RUN (priority order, highest first):
1. halt_mem_wb → next state HALT. All enables 0 in this cycle.
2. memwait → next state MEM_WAIT. All five enables 0 in this cycle, no flushes.
3. branch_taken_ex_mem → pc_en=1, if_id_flush=1, id_ex_flush=1, other enables 1. pc_en=1 applies even when ~ihit.
4. loaduse → pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1. Exactly one bubble, since the load advances out of EX.
5. jump_id → if_id_flush=1, all enables 1.
6. ~ihit → pc_en=0, if_id_flush=1, other enables 1.
7. Otherwise all enables 1, no flushes.

MEM_WAIT:
- All enables 0. wait_cnt increments each cycle.
- dhit=1 → that cycle behaves as RUN rules 3-7 with memwait cleared; next state RUN; wait_cnt=0.
- wait_cnt reaching MAX_WAIT-1 sets mem_timeout (sticky). Waiting continues.

HALT:
- All enables 0, halted=1. The only exit is reset.

stall_count:
- Increments on every cycle with nRST=1 and pc_en=0, including HALT.
- Saturates at all-ones.

Decomposition:
- cpu_types_pkg gains typedef fwd_sel_t (2-bit enum FWD_RF, FWD_ALU, FWD_WB, FWD_UP16) and typedef hzd_state_t (RUN, MEM_WAIT, HALT).
- One natural sub-module: forward_sel, the combinational compare block, instantiated twice (A and B).

Test Plan:
- add $3 in EX/MEM, rs_id_ex=3 → forwarda=01. Same cycle with lui_ex_mem=1 → forwarda=11.
- rt_id_ex=5 matches both wsel_ex_mem=5 and wsel_mem_wb=5 → forwardb=01. With wsel_ex_mem=0 and rt_id_ex=0 → forwardb=00.
- lw $4 in EX, rs_if_id=4 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle, with the load in MEM/WB and rs_id_ex=4 → forwarda=10.
- dmemren with dhit low for 3 cycles → all enables 0 for 4 cycles (entry cycle plus 3 wait cycles), stall_count=4. With MAX_WAIT=3, mem_timeout=1 and stays 1 after dhit.
- branch_taken_ex_mem with loaduse and ~ihit in the same cycle → pc_en=1, if_id_flush=1, id_ex_flush=1.
- halt_mem_wb=1 → halted=1 and all enables 0 indefinitely. nRST pulse mid-halt → state RUN and all counters 0.
